girl_motion: RTL and testbench
==============================

Name: girl_motion

Overview:
- Per-frame motion and animation controller for the Watergirl character.
- Sits directly upstream of the character sprite drawer. Consumes keyboard intents and level-collision flags; produces the sprite centre (BallX, BallY), 2-bit animation frame and facing flags that the drawer uses for ROM addressing and mirroring.
- All state advances only on a one-cycle frame_tick pulse (vsync-derived), so motion is one step per displayed frame.

Parameters:
- X_INIT, 320, reset X centre
- Y_INIT, 400, reset Y centre
- X_MIN, 15, leftmost legal centre (half sprite width)
- X_MAX, 624, rightmost legal centre
- Y_MIN, 13, topmost legal centre (half sprite height)
- Y_MAX, 466, bottommost legal centre (floor fallback)
- X_STEP, 2, horizontal pixels per frame
- JUMP_V, 8, initial upward speed, px/frame
- GRAVITY, 1, speed change per frame
- VMAX_FALL, 8, terminal fall speed
- ANIM_DIV, 6, frame_ticks per animation frame while walking

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- key_left  in  1  left key held
- key_right  in  1  right key held
- key_jump  in  1  jump key held
- blocked_left  in  1  wall contact on left side
- blocked_right  in  1  wall contact on right side
- on_ground  in  1  solid tile directly under feet
- head_blocked  in  1  solid tile directly above head
- BallX  out  10  sprite centre X
- BallY  out  10  sprite centre Y
- animation_frame  out  2  walk frame 0..2; value 3 is never produced
- left_moving  out  1  sticky facing-left flag (drives sprite mirror)
- right_moving  out  1  moving right this frame
- airborne  out  1  vertical FSM is not GROUND

Behaviour:
- Reset (synchronous, priority over frame_tick): BallX=X_INIT, BallY=Y_INIT, state=GROUND, vy=0, anim counter=0, animation_frame=0, left_moving=0, right_moving=0, airborne=0, jump_q=0.
- Without frame_tick, all state holds. Inputs are sampled on the frame_tick cycle; outputs change on the next Clk edge (latency 1).
- Horizontal direction: dir = left if key_left&~key_right; right if key_right&~key_left; otherwise none (both keys held = none).
  - Left: BallX = max(BallX-X_STEP, X_MIN) unless blocked_left. Right: BallX = min(BallX+X_STEP, X_MAX) unless blocked_right.
  - left_moving is set on a left dir and cleared on a right dir; it holds when dir=none.
  - right_moving = (dir==right) & ~blocked_right.
- Jump edge: jump_edge = key_jump & ~jump_q. jump_q is updated to key_jump on each frame_tick.
- Vertical FSM (vy is an unsigned 4-bit magnitude):
  - GROUND:
    - If jump_edge & ~head_blocked: go to JUMP, vy=JUMP_V.
    - Else if ~on_ground: go to FALL, vy=0.
    - Else stay; BallY unchanged.
  - JUMP:
    - BallY = max(BallY-vy, Y_MIN), then vy=vy-GRAVITY.
    - Go to FALL with vy=0 if head_blocked, if the new vy==0, or if BallY clamped at Y_MIN.
  - FALL:
    - If on_ground: go to GROUND, vy=0, BallY unchanged.
    - Else vy=min(vy+GRAVITY, VMAX_FALL), then BallY = min(BallY+vy, Y_MAX).
    - Reaching Y_MAX forces GROUND.
- airborne = (state != GROUND).
- Animation:
  - GROUND with right_moving or (left dir & ~blocked_left): counter increments each tick. At ANIM_DIV-1 the counter resets to 0 and frame advances 0→1→2→0.
  - GROUND idle: frame=0, counter=0.
  - Airborne: frame=1, counter=0.
- All coordinate arithmetic uses 11-bit intermediates so clamps never wrap.

Optional Feature:
- Macro: GIRL_DOUBLE_JUMP_EN.
- Defined: one extra jump per airtime. In JUMP or FALL, jump_edge & ~head_blocked with the double-jump token unused causes JUMP with vy=JUMP_V and consumes the token. The token is restored on entry to GROUND and on Reset.
- Undefined: jump_edge is ignored while airborne and no token logic is synthesized.

Test Plan:
- Reset then 10 frame_ticks with no keys and on_ground=1 → BallX=320, BallY=400, frame=0, airborne=0 throughout.
- key_right held for 20 ticks, on_ground=1 → BallX=360, right_moving=1, left_moving=0, frame sequence 0(6 ticks),1(6),2(6),0, counter correct.
- key_left held 200 ticks from X=320 → BallX saturates at 15, never wraps; left_moving stays 1 after release. Both keys held → BallX constant, frame=0.
- Jump edge at Y=400 with on_ground=1 → BallY 392,385,379,374,370,367,365,364 (vy 8..1), then FALL. Assert on_ground when back near 400 → GROUND, airborne=0. Holding key_jump does not re-jump without a release.
- head_blocked asserted on 2nd JUMP tick → immediate FALL with vy=0. Reset asserted mid-FALL coincident with frame_tick → next cycle all outputs at reset values.
- With GIRL_DOUBLE_JUMP_EN: second jump edge in FALL → vy=8 upward. Third edge is ignored until landing. Without the macro, the second edge is ignored.

Source files
------------

// File: rtl/girl_motion.sv
// girl_motion: per-frame motion and animation controller for the Watergirl sprite.
// Produces the sprite centre, walk animation frame and facing flags. All state
// advances only on the one-cycle frame_tick pulse.
// Optional feature: define GIRL_DOUBLE_JUMP_EN to allow one extra jump per airtime.

module girl_motion #(
   parameter int unsigned X_INIT    = 320,
   parameter int unsigned Y_INIT    = 400,
   parameter int unsigned X_MIN     = 15,
   parameter int unsigned X_MAX     = 624,
   parameter int unsigned Y_MIN     = 13,
   parameter int unsigned Y_MAX     = 466,
   parameter int unsigned X_STEP    = 2,
   parameter int unsigned JUMP_V    = 8,
   parameter int unsigned GRAVITY   = 1,
   parameter int unsigned VMAX_FALL = 8,
   parameter int unsigned ANIM_DIV  = 6
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_jump,
   input  logic       blocked_left,
   input  logic       blocked_right,
   input  logic       on_ground,
   input  logic       head_blocked,
   output logic [9:0] BallX,
   output logic [9:0] BallY,
   output logic [1:0] animation_frame,
   output logic       left_moving,
   output logic       right_moving,
   output logic       airborne
);

   typedef enum logic [1:0] {GROUND, JUMP, FALL} vstate_e;

   localparam int unsigned CNT_W = (ANIM_DIV > 2) ? $clog2(ANIM_DIV) : 1;

   // 11-bit versions of the bounds so sums and differences never wrap
   localparam logic [10:0] X_MIN_W  = 11'(X_MIN);
   localparam logic [10:0] X_MAX_W  = 11'(X_MAX);
   localparam logic [10:0] X_STEP_W = 11'(X_STEP);
   localparam logic [10:0] Y_MIN_W  = 11'(Y_MIN);
   localparam logic [10:0] Y_MAX_W  = 11'(Y_MAX);
   localparam logic [9:0]  X_MIN_Q  = 10'(X_MIN);
   localparam logic [9:0]  X_MAX_Q  = 10'(X_MAX);
   localparam logic [9:0]  Y_MIN_Q  = 10'(Y_MIN);
   localparam logic [9:0]  Y_MAX_Q  = 10'(Y_MAX);
   localparam logic [3:0]  JUMP_V_Q = 4'(JUMP_V);
   localparam logic [3:0]  GRAV_Q   = 4'(GRAVITY);
   localparam logic [3:0]  VMAX_Q   = 4'(VMAX_FALL);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   vstate_e          state_q;
   logic [9:0]       x_q, y_q;
   logic [3:0]       vy_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       frame_q;
   logic             left_q, right_q, air_q, jump_q;
`ifdef GIRL_DOUBLE_JUMP_EN
   logic             tok_q;
`endif

   logic        go_left, go_right, right_mv_d, walking, jump_edge;
   logic [10:0] x_w, y_w, vy_w, y_sink_w;
   logic [4:0]  vy_inc_w;
   logic [9:0]  x_d, y_rise_d, y_sink_d;
   logic [3:0]  vy_dec_d, vy_fall_d;
   logic        rise_stop, sink_floor;

   // Next-position arithmetic for horizontal walk, jump rise and fall
   always_comb begin
      // NOTE: every combinational output gets an unconditional default first so no path can infer a latch.
      go_left    = key_left & ~key_right;
      go_right   = key_right & ~key_left;
      right_mv_d = go_right & ~blocked_right;
      walking    = right_mv_d | (go_left & ~blocked_left);
      jump_edge  = key_jump & ~jump_q;

      x_w = {1'b0, x_q};
      x_d = x_q;
      if (go_left && !blocked_left)
         x_d = (x_w < X_MIN_W + X_STEP_W) ? X_MIN_Q : 10'(x_w - X_STEP_W);
      else if (right_mv_d)
         x_d = (x_w + X_STEP_W > X_MAX_W) ? X_MAX_Q : 10'(x_w + X_STEP_W);

      y_w      = {1'b0, y_q};
      vy_w     = {7'd0, vy_q};
      y_rise_d = (y_w < Y_MIN_W + vy_w) ? Y_MIN_Q : 10'(y_w - vy_w);
      vy_dec_d = vy_q - GRAV_Q;
      rise_stop = head_blocked || (vy_dec_d == 4'd0) || (y_rise_d == Y_MIN_Q);

      vy_inc_w   = {1'b0, vy_q} + {1'b0, GRAV_Q};
      vy_fall_d  = (vy_inc_w > {1'b0, VMAX_Q}) ? VMAX_Q : vy_inc_w[3:0];
      y_sink_w   = y_w + {7'd0, vy_fall_d};
      y_sink_d   = (y_sink_w > Y_MAX_W) ? Y_MAX_Q : 10'(y_sink_w);
      sink_floor = (y_sink_d == Y_MAX_Q);
   end

   // Frame-rate state: position, vertical FSM, facing and animation, all registered
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (Reset) begin
         state_q <= GROUND;
         x_q     <= 10'(X_INIT);
         y_q     <= 10'(Y_INIT);
         vy_q    <= 4'd0;
         cnt_q   <= '0;
         frame_q <= 2'd0;
         left_q  <= 1'b0;
         right_q <= 1'b0;
         air_q   <= 1'b0;
         jump_q  <= 1'b0;
`ifdef GIRL_DOUBLE_JUMP_EN
         tok_q   <= 1'b1;
`endif
      end else if (frame_tick) begin
         x_q     <= x_d;
         jump_q  <= key_jump;
         right_q <= right_mv_d;
         if (go_left)       left_q <= 1'b1;
         else if (go_right) left_q <= 1'b0;

         case (state_q)
            GROUND: begin
               if (jump_edge && !head_blocked) begin
                  state_q <= JUMP;
                  vy_q    <= JUMP_V_Q;
                  air_q   <= 1'b1;
               end else if (!on_ground) begin
                  state_q <= FALL;
                  vy_q    <= 4'd0;
                  air_q   <= 1'b1;
               end
            end
            JUMP, FALL: begin
`ifdef GIRL_DOUBLE_JUMP_EN
               if (jump_edge && !head_blocked && tok_q) begin
                  state_q <= JUMP;
                  vy_q    <= JUMP_V_Q;
                  tok_q   <= 1'b0;
               end else
`endif
               if (state_q == JUMP) begin
                  y_q <= y_rise_d;
                  if (rise_stop) begin
                     state_q <= FALL;
                     vy_q    <= 4'd0;
                  end else begin
                     vy_q <= vy_dec_d;
                  end
               end else if (on_ground || sink_floor) begin
                  if (!on_ground) y_q <= y_sink_d;
                  state_q <= GROUND;
                  vy_q    <= 4'd0;
                  air_q   <= 1'b0;
`ifdef GIRL_DOUBLE_JUMP_EN
                  tok_q   <= 1'b1;
`endif
               end else begin
                  y_q  <= y_sink_d;
                  vy_q <= vy_fall_d;
               end
            end
            default: begin
               state_q <= GROUND;
               vy_q    <= 4'd0;
               air_q   <= 1'b0;
            end
         endcase

         if (state_q != GROUND) begin
            frame_q <= 2'd1;
            cnt_q   <= '0;
         end else if (walking) begin
            if (cnt_q == CNT_LAST) begin
               cnt_q   <= '0;
               frame_q <= (frame_q == 2'd2) ? 2'd0 : frame_q + 2'd1;
            end else begin
               cnt_q <= cnt_q + CNT_ONE;
            end
         end else begin
            frame_q <= 2'd0;
            cnt_q   <= '0;
         end
      end
   end

   assign BallX           = x_q;
   assign BallY           = y_q;
   assign animation_frame = frame_q;
   assign left_moving     = left_q;
   assign right_moving    = right_q;
   assign airborne        = air_q;

endmodule

// File: tb/tb_girl_motion.sv
// tb_girl_motion: directed and randomized frame-tick stimulus for girl_motion,
// checked every cycle against a behavioural model plus literal expectations.

module tb_girl_motion;

   logic       Clk = 1'b0;
   logic       Reset, frame_tick;
   logic       key_left, key_right, key_jump;
   logic       blocked_left, blocked_right, on_ground, head_blocked;
   logic [9:0] BallX, BallY;
   logic [1:0] animation_frame;
   logic       left_moving, right_moving, airborne;

   int n_checks = 0;
   int n_pass   = 0;
   bit check_en = 1'b0;

   girl_motion dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
      .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
      .blocked_left(blocked_left), .blocked_right(blocked_right),
      .on_ground(on_ground), .head_blocked(head_blocked),
      .BallX(BallX), .BallY(BallY), .animation_frame(animation_frame),
      .left_moving(left_moving), .right_moving(right_moving), .airborne(airborne)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int mx, my, mvy, mcnt, mframe;
   bit mair, mup, mleft, mright, mjq;
`ifdef GIRL_DOUBLE_JUMP_EN
   bit mtok;
`endif

   task automatic model_reset();
      mx = 320; my = 400; mvy = 0; mcnt = 0; mframe = 0;
      mair = 0; mup = 0; mleft = 0; mright = 0; mjq = 0;
`ifdef GIRL_DOUBLE_JUMP_EN
      mtok = 1;
`endif
   endtask

   task automatic land();
      mair = 0; mvy = 0;
`ifdef GIRL_DOUBLE_JUMP_EN
      mtok = 1;
`endif
   endtask

   task automatic model_step();
      bit l, r, jedge, was_air, walk;
      l = key_left && !key_right;
      r = key_right && !key_left;
      walk = (r && !blocked_right) || (l && !blocked_left);
      was_air = mair;
      if (l && !blocked_left) mx = (mx - 2 < 15) ? 15 : mx - 2;
      else if (r && !blocked_right) mx = (mx + 2 > 624) ? 624 : mx + 2;
      if (l) mleft = 1; else if (r) mleft = 0;
      mright = r && !blocked_right;
      jedge = key_jump && !mjq;
      mjq = key_jump;

      if (!mair) begin
         if (jedge && !head_blocked) begin mair = 1; mup = 1; mvy = 8; end
         else if (!on_ground) begin mair = 1; mup = 0; mvy = 0; end
      end
`ifdef GIRL_DOUBLE_JUMP_EN
      else if (jedge && !head_blocked && mtok) begin mup = 1; mvy = 8; mtok = 0; end
`endif
      else if (mup) begin
         my = (my - mvy < 13) ? 13 : my - mvy;
         mvy = mvy - 1;
         if (head_blocked || mvy == 0 || my == 13) begin mup = 0; mvy = 0; end
      end else if (on_ground) begin
         land();
      end else begin
         mvy = (mvy + 1 > 8) ? 8 : mvy + 1;
         my = (my + mvy > 466) ? 466 : my + mvy;
         if (my == 466) land();
      end

      if (was_air) begin mframe = 1; mcnt = 0; end
      else if (walk) begin
         if (mcnt == 5) begin mcnt = 0; mframe = (mframe + 1) % 3; end
         else mcnt++;
      end else begin mframe = 0; mcnt = 0; end
   endtask

   always @(posedge Clk) begin
      if (Reset) model_reset();
      else if (frame_tick) model_step();
   end

   // Compare process: DUT against model on every falling edge
   always @(negedge Clk) begin
      if (check_en)
         check("model", 32'({BallX, BallY, animation_frame, left_moving, right_moving, airborne}),
               32'({10'(mx), 10'(my), 2'(mframe), mleft, mright, mair}));
   end

   // ---------------- stimulus ----------------
   task automatic tick(input bit l, r, j, bl, br, og, hb);
      key_left = l; key_right = r; key_jump = j;
      blocked_left = bl; blocked_right = br; on_ground = og; head_blocked = hb;
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge Clk);
   endtask

   task automatic do_reset(input bit with_tick);
      Reset = 1'b1;
      frame_tick = with_tick;
      @(negedge Clk);
      Reset = 1'b0;
      frame_tick = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_x"}, 32'(BallX), 32'd320);
      check({tag, "_y"}, 32'(BallY), 32'd400);
      check({tag, "_flags"},
            32'({animation_frame, left_moving, right_moving, airborne}), 32'd0);
   endtask

   initial begin
      int up_y[8];
      int fall_y[8];
      up_y   = '{392, 385, 379, 374, 370, 367, 365, 364};
      fall_y = '{365, 367, 370, 374, 379, 385, 392, 400};

      Reset = 1'b1; frame_tick = 1'b0;
      key_left = 0; key_right = 0; key_jump = 0;
      blocked_left = 0; blocked_right = 0; on_ground = 1; head_blocked = 0;
      @(negedge Clk);
      @(negedge Clk);
      check_en = 1'b1;
      Reset = 1'b0;
      check_reset_state("reset");

      // idle on the ground
      for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 0, 1, 0);
      check_reset_state("idle");

      // walk right: frame advances every 6 ticks
      for (int k = 1; k <= 20; k++) begin
         tick(0, 1, 0, 0, 0, 1, 0);
         check("walk_frame", 32'(animation_frame), 32'((k / 6) % 3));
      end
      check("walk_x", 32'(BallX), 32'd360);
      check("walk_dirs", 32'({left_moving, right_moving}), 32'b01);

      // walk left into the wall clamp
      for (int i = 0; i < 200; i++) tick(1, 0, 0, 0, 0, 1, 0);
      check("left_clamp_x", 32'(BallX), 32'd15);
      tick(0, 0, 0, 0, 0, 1, 0);
      check("left_sticky", 32'({left_moving, right_moving}), 32'b10);
      for (int i = 0; i < 5; i++) tick(1, 1, 0, 0, 0, 1, 0);
      check("both_keys", 32'({BallX, animation_frame}), 32'({10'd15, 2'd0}));

      // walk right into the right clamp
      for (int i = 0; i < 320; i++) tick(0, 1, 0, 0, 0, 1, 0);
      check("right_clamp_x", 32'(BallX), 32'd624);

      // full jump arc from Y=400
      do_reset(1'b1);
      tick(0, 0, 1, 0, 0, 1, 0);
      check("jump_start", 32'({BallY, airborne}), 32'({10'd400, 1'b1}));
      for (int i = 0; i < 8; i++) begin
         tick(0, 0, 1, 0, 0, 0, 0);
         check("jump_rise_y", 32'(BallY), 32'(up_y[i]));
      end
      for (int i = 0; i < 8; i++) begin
         tick(0, 0, 1, 0, 0, 0, 0);
         check("jump_fall_y", 32'(BallY), 32'(fall_y[i]));
      end
      tick(0, 0, 1, 0, 0, 1, 0);
      check("landed", 32'({BallY, airborne}), 32'({10'd400, 1'b0}));
      tick(0, 0, 1, 0, 0, 1, 0);
      check("held_no_rejump", 32'(airborne), 32'd0);

      // head bump on the second rising tick
      tick(0, 0, 0, 0, 0, 1, 0);
      tick(0, 0, 1, 0, 0, 1, 0);
      tick(0, 0, 0, 0, 0, 0, 0);
      check("bump_rise1", 32'(BallY), 32'd392);
      tick(0, 0, 0, 0, 0, 0, 1);
      check("bump_rise2", 32'({BallY, airborne}), 32'({10'd385, 1'b1}));
      tick(0, 1, 0, 0, 0, 0, 0);
      check("bump_fall_vy0", 32'(BallY), 32'd386);

      // reset coincident with frame_tick mid-fall
      do_reset(1'b1);
      check_reset_state("mid_fall_reset");

      // randomized play; odd blocks keep landing at once so jumps climb to the ceiling
      for (int i = 0; i < 3000; i++) begin
         bit climb, og;
         climb = ((i / 400) % 2) == 1;
         og = climb ? 1'b1 : ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 299) == 0) do_reset($urandom_range(0, 1) == 1);
         tick($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              og, $urandom_range(0, 15) == 0);
      end

      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
